serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//   Parametrised multi-cycle adder/subtractor; next generation of the 1-bit half adder.
//   Adds or subtracts two WIDTH-bit operands DIGIT bits per clock using a shared DIGIT-bit adder slice.
//   Carry propagates between cycles through a carry flop. Start/busy/done handshake.
//   Used where area matters more than latency, e.g. accumulators and checksum units.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; >= 2
//   DIGIT  1  bits processed per cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0
//   (derived) STEPS = WIDTH/DIGIT; count register width = $clog2(STEPS)+1
// PORTS
//   i_clk       in   1      clock; all state changes on rising edge
//   i_rst_n     in   1      asynchronous reset, active low
//   i_start     in   1      request; sampled only in IDLE or DONE
//   i_a         in   WIDTH  operand A; captured on accepted start
//   i_b         in   WIDTH  operand B; captured on accepted start
//   i_cin       in   1      carry-in (add) / borrow-in (sub); captured on accepted start
//   i_sub       in   1      0: A+B+cin, 1: A-B-cin; captured on accepted start
//   o_busy      out  1      high while in RUN
//   o_done      out  1      one-cycle pulse; result valid
//   sum         out  WIDTH  result; holds until the next completion
//   carry       out  1      raw carry-out of MSB; in sub mode 1 = no borrow
//   o_overflow  out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   Reset (i_rst_n=0, async):
//     State = IDLE. o_busy, o_done, sum, carry, o_overflow, shift regs and count = 0.
//   FSM: IDLE -> RUN -> DONE -> (IDLE | RUN)
//   Start accept:
//     - Condition: i_start=1 at edge k while in IDLE or DONE.
//     - Latch opA = i_a, opB = i_sub ? ~i_b : i_b, c = i_sub ? ~i_cin : i_cin.
//     - count = 0, state = RUN.
//   RUN, each edge:
//     - {c, digit} = opA[DIGIT-1:0] + opB[DIGIT-1:0] + c.
//     - digit shifts into the result MSB end; opA and opB shift right by DIGIT; count++.
//     - Final step also records carry into bit WIDTH-1 for overflow.
//   Completion:
//     - At edge k+STEPS, state = DONE and o_done = 1.
//     - sum, carry and o_overflow update at this edge only.
//   Latency: STEPS cycles from the accepting edge to o_done high.
//     Example: WIDTH=8, DIGIT=1 -> 8 cycles.
//   DONE:
//     - Lasts exactly one cycle. o_done drops at the next edge.
//     - Next state is RUN if i_start=1 (back-to-back accept, o_done not re-asserted in between), else IDLE.
//   i_start during RUN: ignored, no queuing. Operand changes during RUN have no effect.
//   Reset mid-RUN: operation discarded; the previous result is also cleared to 0; no o_done.
//   All arithmetic is modulo 2^WIDTH. carry/overflow are defined for both add and sub modes.
// TESTING
//   1. WIDTH=8, DIGIT=1: add 0xFF+0x01, cin=0
//      -> o_done exactly 8 cycles after start; sum=0x00, carry=1, o_overflow=0.
//   2. Add 0x7F+0x01, cin=0 -> sum=0x80, carry=0, o_overflow=1.
//      Add 0x00+0x00, cin=1 -> sum=0x01.
//   3. Sub 0x05-0x07, cin=0 -> sum=0xFE, carry=0, ovf=0.
//      Sub 0x80-0x01 -> sum=0x7F, carry=1, ovf=1.
//   4. Pulse i_start again at RUN cycle 3 with new operands -> ignored; result reflects the first operands.
//      Start held high in the DONE cycle -> second op accepted, its o_done 8 cycles later.
//   5. Drop i_rst_n at RUN cycle 4 -> all outputs 0 immediately, no o_done.
//      After release a fresh add 0x12+0x34 -> sum=0x46.
//   6. Random: 200 ops each for DIGIT=1,2,4,8 (WIDTH=8) and WIDTH=16/DIGIT=4.
//      Compare against model {carry,sum} = A + (sub ? ~B : B) + (sub ? ~cin : cin).
//      Check overflow and latency == STEPS on every op.

Source files
------------

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: one shared DIGIT-bit adder slice, STEPS cycles per operation.
// Operands are shifted right through the slice, LSB digit first, with carry held in a flop.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             o_overflow,
  output logic [1:0]       o_dbg_state
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS) + 1;

  // Handshake: i_start is a request taken only when the unit is IDLE or in its
  // DONE cycle (no queuing). o_busy is high for the STEPS RUN cycles; o_done is
  // a one-cycle pulse marking sum/carry/o_overflow valid, held until the next one.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             last_step;
  logic [DIGIT:0]   slice_w;
  logic [DIGIT-1:0] digit_w;
  logic             cout_w;
  logic             cin_msb_w;

  assign accept    = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_step = (state_q == ST_RUN) && (cnt_q == CW'(STEPS - 1));

  assign slice_w = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
  assign digit_w = slice_w[DIGIT-1:0];
  assign cout_w  = slice_w[DIGIT];
  // On the last step the slice sees the operand MSBs; recover the carry into the MSB.
  assign cin_msb_w = digit_w[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = i_start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy      = (state_q == ST_RUN);
    o_done      = (state_q == ST_DONE);
    o_dbg_state = state_q;
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d   = i_a;
      b_d   = i_sub ? ~i_b : i_b;
      c_d   = i_sub ^ i_cin;
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      c_d   = cout_w;
      res_d = (res_q >> DIGIT) | (WIDTH'(digit_w) << (WIDTH - DIGIT));
      cnt_d = cnt_q + CW'(1);
      if (last_step) begin
        sum_d   = res_d;
        carry_d = cout_w;
        ovf_d   = cin_msb_w ^ cout_w;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum        = sum_q;
  assign carry      = carry_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: five instances (WIDTH 8 with DIGIT 1/2/4/8, WIDTH 16 with DIGIT 4)
// share stimulus; instance 0 (8/1) carries the directed scenarios.
module tb_serial_add_sub;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a_drv = '0;
  logic [15:0] b_drv = '0;

  logic        busy_v [N];
  logic        done_v [N];
  logic        carry_v[N];
  logic        ovf_v  [N];
  logic [15:0] sum_v  [N];
  logic [1:0]  st_v   [N];
  logic [7:0]  sum8   [4];

  int          n_checks = 0;
  int          n_fail = 0;

  int          lat_r  [N];
  logic [15:0] sum_r  [N];
  logic        carry_r[N];
  logic        ovf_r  [N];
  logic        busy_r [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_w8
    serial_add_sub #(.WIDTH(8), .DIGIT(1 << g)) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .i_a(a_drv[7:0]), .i_b(b_drv[7:0]), .i_cin(cin), .i_sub(sub),
      .o_busy(busy_v[g]), .o_done(done_v[g]), .sum(sum8[g]),
      .carry(carry_v[g]), .o_overflow(ovf_v[g]), .o_dbg_state(st_v[g])
    );
    assign sum_v[g] = {8'h00, sum8[g]};
  end

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_a(a_drv), .i_b(b_drv), .i_cin(cin), .i_sub(sub),
    .o_busy(busy_v[4]), .o_done(done_v[4]), .sum(sum_v[4]),
    .carry(carry_v[4]), .o_overflow(ovf_v[4]), .o_dbg_state(st_v[4])
  );

  function automatic int width_of(int i);
    return (i < 4) ? 8 : 16;
  endfunction

  function automatic int steps_of(int i);
    return (i < 4) ? (8 >> i) : 4;
  endfunction

  // Reference: {ovf, carry, sum} from plain integer arithmetic on the effective operands
  function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b, logic ci, logic sb);
    longint mask, av, bv, cv, full, s;
    logic   cy, ov;
    mask = (longint'(1) << w) - 1;
    av   = longint'(a) & mask;
    bv   = longint'(sb ? ~b : b) & mask;
    cv   = (sb ? !ci : ci) ? 1 : 0;
    full = av + bv + cv;
    s    = full & mask;
    cy   = ((full >> w) & 1) != 0;
    ov   = (((av >> (w - 1)) & 1) == ((bv >> (w - 1)) & 1)) &&
           (((s >> (w - 1)) & 1) != ((av >> (w - 1)) & 1));
    return {ov, cy, s[15:0]};
  endfunction

  // Driver: one accepted start broadcast to every instance, collect each result and latency
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    logic got[N];
    logic all_got;
    @(negedge clk);
    a_drv = a; b_drv = b; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      got[i] = 1'b0; lat_r[i] = -1; busy_r[i] = busy_v[i];
      if (steps_of(i) == 0) got[i] = 1'b1;
    end
    all_got = 1'b0;
    for (int cyc = 1; cyc <= 40 && !all_got; cyc++) begin
      @(posedge clk); #1;
      all_got = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (done_v[i] && !got[i]) begin
          got[i] = 1'b1; lat_r[i] = cyc;
          sum_r[i] = sum_v[i]; carry_r[i] = carry_v[i]; ovf_r[i] = ovf_v[i];
        end
        if (!got[i]) all_got = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({busy_v[i], done_v[i], carry_v[i], ovf_v[i], sum_v[i], st_v[i]} !== 22'h0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got busy=%b done=%b carry=%b ovf=%b sum=%h st=%0d required all 0",
                 i, busy_v[i], done_v[i], carry_v[i], ovf_v[i], sum_v[i], st_v[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_dir(input string name, input logic [7:0] es, input logic ec, input logic eo);
    n_checks++;
    if (lat_r[0] !== 8) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d required 8", name, lat_r[0]);
    end
    n_checks++;
    if ({ovf_r[0], carry_r[0], sum_r[0]} !== {eo, ec, 8'h00, es}) begin
      n_fail++;
      $display("FAIL %s_result: got sum=%h carry=%b ovf=%b required sum=%h carry=%b ovf=%b",
               name, sum_r[0][7:0], carry_r[0], ovf_r[0], es, ec, eo);
    end
  endtask

  task automatic test_add_directed();
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    check_dir("add_ff_01", 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (busy_r[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_accept: got %b required 1", busy_r[0]);
    end
    run_op(16'h007F, 16'h0001, 1'b0, 1'b0);
    check_dir("add_7f_01", 8'h80, 1'b0, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    check_dir("add_cin", 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_sub_directed();
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    check_dir("sub_05_07", 8'hFE, 1'b0, 1'b0);
    run_op(16'h0080, 16'h0001, 1'b0, 1'b1);
    check_dir("sub_80_01", 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_start_during_run();
    int lat;
    logic [7:0] s;
    @(negedge clk);
    a_drv = 16'h11; b_drv = 16'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_drv = 16'h55; b_drv = 16'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; s = 8'h00;
    for (int c = 4; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin lat = c; s = sum_v[0][7:0]; break; end
    end
    n_checks++;
    if (lat !== 8 || s !== 8'h33) begin
      n_fail++;
      $display("FAIL ignore_start_in_run: got lat=%0d sum=%h required lat=8 sum=33", lat, s);
    end
    // Hold start through the DONE cycle for a back-to-back accept
    a_drv = 16'h20; b_drv = 16'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back_accept: got done=%b busy=%b required done=0 busy=1", done_v[0], busy_v[0]);
    end
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin lat = c; s = sum_v[0][7:0]; break; end
    end
    n_checks++;
    if (lat !== 8 || s !== 8'h23) begin
      n_fail++;
      $display("FAIL back_to_back_result: got lat=%0d sum=%h required lat=8 sum=23", lat, s);
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    int n_done;
    @(negedge clk);
    a_drv = 16'h40; b_drv = 16'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_v[0], done_v[0], carry_v[0], ovf_v[0], sum_v[0]} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got busy=%b done=%b carry=%b ovf=%b sum=%h required all 0",
               busy_v[0], done_v[0], carry_v[0], ovf_v[0], sum_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_v[0]) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: got %0d pulses required 0", n_done);
    end
    run_op(16'h0012, 16'h0034, 1'b0, 1'b0);
    check_dir("add_after_reset", 8'h46, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic        ci, sb;
    logic [17:0] exp_v;
    for (int n = 0; n < 200; n++) begin
      a = 16'($urandom); b = 16'($urandom);
      ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op(a, b, ci, sb);
      for (int i = 0; i < N; i++) begin
        exp_v = model(width_of(i), a, b, ci, sb);
        n_checks++;
        if (lat_r[i] !== steps_of(i)) begin
          n_fail++;
          $display("FAIL rand_latency[%0d] op%0d: got %0d required %0d", i, n, lat_r[i], steps_of(i));
        end
        n_checks++;
        if (busy_r[i] !== (steps_of(i) > 0)) begin
          n_fail++;
          $display("FAIL rand_busy[%0d] op%0d: got %b required 1", i, n, busy_r[i]);
        end
        n_checks++;
        if (sum_r[i] !== exp_v[15:0]) begin
          n_fail++;
          $display("FAIL rand_sum[%0d] op%0d: got %h required %h", i, n, sum_r[i], exp_v[15:0]);
        end
        n_checks++;
        if (carry_r[i] !== exp_v[16]) begin
          n_fail++;
          $display("FAIL rand_carry[%0d] op%0d: got %b required %b", i, n, carry_r[i], exp_v[16]);
        end
        n_checks++;
        if (ovf_r[i] !== exp_v[17]) begin
          n_fail++;
          $display("FAIL rand_ovf[%0d] op%0d: got %b required %b", i, n, ovf_r[i], exp_v[17]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_directed();
    test_sub_directed();
    test_start_during_run();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
